// File: rtl/mu0_control_if.sv
// MU0 control-unit bus: opcode/flags/memory-ready in, datapath
// strobes and instruction count out.
interface mu0_control_if;
    logic [3:0]  F;
    logic        N;
    logic        Z;
    logic        MemRdy;
    logic        MEMrq;
    logic        RnW;
    logic        Addr_sel;
    logic        X_sel;
    logic        Y_sel;
    logic [1:0]  ALU_fs;
    logic        Acc_en;
    logic        PC_en;
    logic        IR_en;
    logic        Acc_oe;
    logic        Halted;
    logic [15:0] InstrCount;

    modport master (
        input  F, N, Z, MemRdy,
        output MEMrq, RnW, Addr_sel, X_sel, Y_sel, ALU_fs,
        output Acc_en, PC_en, IR_en, Acc_oe, Halted, InstrCount
    );

    modport slave (
        output F, N, Z, MemRdy,
        input  MEMrq, RnW, Addr_sel, X_sel, Y_sel, ALU_fs,
        input  Acc_en, PC_en, IR_en, Acc_oe, Halted, InstrCount
    );
endinterface

// File: rtl/mu0_control.sv
// MU0 control FSM (FETCH/EXEC/HALT) with a saturating
// completed-instruction counter.
module mu0_control (
    input  logic          Clk,
    input  logic          Reset,
    mu0_control_if.master bus
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] count_q, count_d;

    logic       memrq, rnw, addr_sel, x_sel, y_sel;
    logic [1:0] alu_fs;
    logic       acc_en, pc_en, ir_en, acc_oe, halted;
    logic       done;

    always_comb begin
        state_d  = state_q;
        memrq    = 1'b0;
        rnw      = 1'b0;
        addr_sel = 1'b0;
        x_sel    = 1'b0;
        y_sel    = 1'b0;
        alu_fs   = 2'b00;
        acc_en   = 1'b0;
        pc_en    = 1'b0;
        ir_en    = 1'b0;
        acc_oe   = 1'b0;
        halted   = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                memrq  = 1'b1;
                rnw    = 1'b1;
                alu_fs = 2'b11;
                ir_en  = bus.MemRdy;
                pc_en  = bus.MemRdy;
                if (bus.MemRdy)
                    state_d = S_EXEC;
            end
            S_EXEC: begin
                unique case (bus.F)
                    4'd0, 4'd2, 4'd3: begin
                        memrq    = 1'b1;
                        rnw      = 1'b1;
                        addr_sel = 1'b1;
                        y_sel    = 1'b1;
                        x_sel    = (bus.F != 4'd0);
                        alu_fs   = (bus.F == 4'd2) ? 2'b01 :
                                   (bus.F == 4'd3) ? 2'b10 : 2'b00;
                        acc_en   = bus.MemRdy;
                        state_d  = bus.MemRdy ? S_FETCH : S_EXEC;
                    end
                    4'd1: begin
                        memrq    = 1'b1;
                        addr_sel = 1'b1;
                        acc_oe   = 1'b1;
                        state_d  = bus.MemRdy ? S_FETCH : S_EXEC;
                    end
                    4'd4: begin
                        pc_en   = 1'b1;
                        state_d = S_FETCH;
                    end
                    4'd5: begin
                        pc_en   = ~bus.N;
                        state_d = S_FETCH;
                    end
                    4'd6: begin
                        pc_en   = ~bus.Z;
                        state_d = S_FETCH;
                    end
                    4'd7: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset must silence the bus even mid-access, before the async clear lands.
        if (Reset) begin
            memrq  = 1'b0;
            acc_en = 1'b0;
            pc_en  = 1'b0;
            ir_en  = 1'b0;
            acc_oe = 1'b0;
            halted = 1'b0;
        end
    end

    assign done    = (state_q == S_EXEC) && (state_d != S_EXEC);
    assign count_d = (done && (count_q != 16'hFFFF)) ? count_q + 16'd1 : count_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_FETCH;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign bus.MEMrq      = memrq;
    assign bus.RnW        = rnw;
    assign bus.Addr_sel   = addr_sel;
    assign bus.X_sel      = x_sel;
    assign bus.Y_sel      = y_sel;
    assign bus.ALU_fs     = alu_fs;
    assign bus.Acc_en     = acc_en;
    assign bus.PC_en      = pc_en;
    assign bus.IR_en      = ir_en;
    assign bus.Acc_oe     = acc_oe;
    assign bus.Halted     = halted;
    assign bus.InstrCount = count_q;

endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control: strobe vectors, stalls, branches,
// halt, reset mid-access and counter saturation.
module tb_mu0_control;

    logic Clk;
    logic Reset;
    int   n_total;
    int   n_pass;

    mu0_control_if bus ();

    mu0_control dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // MEMrq RnW Addr X Y ALU[1:0] Acc PC IR oe Halted
    wire [11:0] ov = {bus.MEMrq, bus.RnW, bus.Addr_sel, bus.X_sel,
                      bus.Y_sel, bus.ALU_fs, bus.Acc_en, bus.PC_en,
                      bus.IR_en, bus.Acc_oe, bus.Halted};
    wire [5:0]  rv = {bus.MEMrq, bus.Acc_en, bus.PC_en,
                      bus.IR_en, bus.Acc_oe, bus.Halted};

    localparam logic [11:0] V_FETCH  = 12'b1_1_0_0_0_11_0_1_1_0_0;
    localparam logic [11:0] V_FETCHW = 12'b1_1_0_0_0_11_0_0_0_0_0;
    localparam logic [11:0] V_LDA    = 12'b1_1_1_0_1_00_1_0_0_0_0;
    localparam logic [11:0] V_ADDW   = 12'b1_1_1_1_1_01_0_0_0_0_0;
    localparam logic [11:0] V_ADD    = 12'b1_1_1_1_1_01_1_0_0_0_0;
    localparam logic [11:0] V_SUB    = 12'b1_1_1_1_1_10_1_0_0_0_0;
    localparam logic [11:0] V_STA    = 12'b1_0_1_0_0_00_0_0_0_1_0;
    localparam logic [11:0] V_JPC    = 12'b0_0_0_0_0_00_0_1_0_0_0;
    localparam logic [11:0] V_ZERO   = 12'b0_0_0_0_0_00_0_0_0_0_0;
    localparam logic [11:0] V_HALT   = 12'b0_0_0_0_0_00_0_0_0_0_1;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total    = 0;
        n_pass     = 0;
        Reset      = 1'b1;
        bus.F      = 4'd1;
        bus.N      = 1'b0;
        bus.Z      = 1'b0;
        bus.MemRdy = 1'b1;
        #2;
        chk("reset_strobes", {10'd0, rv}, 16'd0);
        chk("reset_count", bus.InstrCount, 16'h0000);

        // LDA, single-cycle memory
        cyc();
        Reset = 1'b0;
        bus.F = 4'd0;
        #1 chk("lda_fetch", {4'd0, ov}, {4'd0, V_FETCH});
        cyc();
        #1 chk("lda_exec", {4'd0, ov}, {4'd0, V_LDA});
        chk("lda_cnt_before", bus.InstrCount, 16'd0);

        // ADD with three wait cycles
        cyc();
        bus.F = 4'd2;
        #1 chk("add_fetch", {4'd0, ov}, {4'd0, V_FETCH});
        chk("lda_cnt", bus.InstrCount, 16'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            bus.MemRdy = 1'b0;
            #1 chk($sformatf("add_wait%0d", i), {4'd0, ov}, {4'd0, V_ADDW});
        end
        cyc();
        bus.MemRdy = 1'b1;
        #1 chk("add_rdy", {4'd0, ov}, {4'd0, V_ADD});
        chk("add_cnt_before", bus.InstrCount, 16'd1);

        // SUB after a stalled fetch
        cyc();
        bus.F      = 4'd3;
        bus.MemRdy = 1'b0;
        #1 chk("sub_fetchw", {4'd0, ov}, {4'd0, V_FETCHW});
        chk("add_cnt", bus.InstrCount, 16'd2);
        cyc();
        bus.MemRdy = 1'b1;
        #1 chk("sub_fetch", {4'd0, ov}, {4'd0, V_FETCH});
        cyc();
        #1 chk("sub_exec", {4'd0, ov}, {4'd0, V_SUB});

        // JGE N=1, MemRdy low must not stall it
        cyc();
        bus.F = 4'd5;
        bus.N = 1'b1;
        #1 chk("sub_cnt", bus.InstrCount, 16'd3);
        cyc();
        bus.MemRdy = 1'b0;
        #1 chk("jge_n1", {4'd0, ov}, {4'd0, V_ZERO});
        cyc();
        bus.MemRdy = 1'b1;
        bus.N      = 1'b0;
        #1 chk("jge_n1_one_cycle", {4'd0, ov}, {4'd0, V_FETCH});
        chk("jge_n1_cnt", bus.InstrCount, 16'd4);
        cyc();
        #1 chk("jge_n0", {4'd0, ov}, {4'd0, V_JPC});

        // JNE Z=1, then JMP
        cyc();
        bus.F = 4'd6;
        bus.Z = 1'b1;
        #1 chk("jge_n0_one_cycle", {4'd0, ov}, {4'd0, V_FETCH});
        cyc();
        #1 chk("jne_z1", {4'd0, ov}, {4'd0, V_ZERO});
        cyc();
        bus.F = 4'd4;
        #1 chk("jne_one_cycle", {4'd0, ov}, {4'd0, V_FETCH});
        cyc();
        #1 chk("jmp", {4'd0, ov}, {4'd0, V_JPC});

        // NOP
        cyc();
        bus.F = 4'd9;
        #1 chk("jmp_cnt", bus.InstrCount, 16'd7);
        cyc();
        #1 chk("nop", {4'd0, ov}, {4'd0, V_ZERO});

        // STA stalled, then reset while MemRdy=1
        cyc();
        bus.F = 4'd1;
        #1 chk("nop_cnt", bus.InstrCount, 16'd8);
        cyc();
        bus.MemRdy = 1'b0;
        #1 chk("sta_wait", {4'd0, ov}, {4'd0, V_STA});
        cyc();
        bus.MemRdy = 1'b1;
        #1 chk("sta_rdy", {4'd0, ov}, {4'd0, V_STA});
        Reset = 1'b1;
        #1 chk("sta_reset_strobes", {10'd0, rv}, 16'd0);
        chk("sta_reset_cnt", bus.InstrCount, 16'd0);

        // STP -> HALT for 12 cycles with MemRdy toggling
        cyc();
        Reset = 1'b0;
        bus.F = 4'd7;
        #1 chk("post_reset_fetch", {4'd0, ov}, {4'd0, V_FETCH});
        cyc();
        #1 chk("stp_exec", {4'd0, ov}, {4'd0, V_ZERO});
        chk("stp_cnt_before", bus.InstrCount, 16'd0);
        for (int i = 0; i < 12; i++) begin
            cyc();
            bus.MemRdy = i[0];
            bus.F      = 4'd0;
            #1 chk($sformatf("halt%0d", i), {4'd0, ov}, {4'd0, V_HALT});
            chk($sformatf("halt_cnt%0d", i), bus.InstrCount, 16'd1);
        end

        // Saturation: preload near the top, then NOPs
        cyc();
        Reset = 1'b1;
        #1;
        Reset      = 1'b0;
        bus.F      = 4'd8;
        bus.MemRdy = 1'b0;
        force dut.count_q = 16'hFFFC;
        cyc();
        release dut.count_q;
        bus.MemRdy = 1'b1;
        #1 chk("sat_preload", bus.InstrCount, 16'hFFFC);
        for (int i = 0; i < 5; i++) begin
            cyc();
            cyc();
            #1 chk($sformatf("sat%0d", i), bus.InstrCount,
                   (i < 3) ? 16'hFFFD + 16'(i) : 16'hFFFF);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
